// File: rtl/fetch_bp_unit.sv
// fetch_bp_unit
//   Instruction-fetch stage with a direct-mapped branch target buffer,
//   2-bit saturating direction counters and a speculative return-address
//   stack. Holds the PC, drives the instruction memory address
//   combinationally and chooses the next PC from, highest priority first:
//   reset, execute redirect, stall (hold), RAS return prediction, BTB
//   taken prediction, PC+4.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   stall_i           hold PC and RAS state
//   redirect_i        load redirect_pc_i (wins over stall_i)
//   redirect_pc_i     corrected PC from execute
//   upd_valid_i       execute resolved a branch/jump this cycle. There is
//                     no ready: an update is accepted in every cycle in
//                     which upd_valid_i is high, and it lands at the next edge.
//   upd_pc_i          PC of the resolved instruction
//   upd_target_i      resolved target
//   upd_taken_i       resolved direction
//   imem_addr_o       instruction memory address (= pc_o)
//   imem_data_i       instruction word, combinational read
//   pc_o, pc_plus4_o  current fetch PC and PC+4
//   instr_o           imem_data_i passthrough
//   pred_taken_o      next PC predicted non-sequential
//   pred_target_o     predicted next PC (PC+4 when not taken)
//   rs1_o/rs2_o/rd_o  register fields of instr_o
module fetch_bp_unit #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    BTB_ENTRIES = 16,
  parameter int                    RAS_DEPTH   = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'hBFC00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  upd_valid_i,
  input  logic [DATA_WIDTH-1:0] upd_pc_i,
  input  logic [DATA_WIDTH-1:0] upd_target_i,
  input  logic                  upd_taken_i,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_data_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  pred_taken_o,
  output logic [DATA_WIDTH-1:0] pred_target_o,
  output logic [4:0]            rs1_o,
  output logic [4:0]            rs2_o,
  output logic [4:0]            rd_o
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] pc_q, pc_d, pc_plus4;

  // Fetch-side decode of calls and returns
  logic [6:0]  opcode;
  logic [4:0]  f_rd, f_rs1;
  logic [11:0] f_imm;
  logic        is_call, is_ret;

  // BTB storage
  logic                  btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]      btb_tag    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0] btb_target [BTB_ENTRIES];
  logic [1:0]            btb_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0] look_idx, upd_idx;
  logic [TAG_W-1:0] look_tag, upd_tag;
  logic             btb_hit, btb_taken, upd_hit;

  // RAS: ras_ptr points at the next free slot, so the top is ras_ptr-1.
  logic [DATA_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]      ras_ptr;
  logic [CNT_W-1:0]      ras_count;
  logic [DATA_WIDTH-1:0] ras_top;
  logic                  ras_hit;
  logic                  advance;

  logic unused_upd_bits;
  assign unused_upd_bits = ^upd_pc_i[1:0];

  assign pc_plus4    = pc_q + DATA_WIDTH'(4);
  assign pc_o        = pc_q;
  assign imem_addr_o = pc_q;
  assign pc_plus4_o  = pc_plus4;
  assign instr_o     = imem_data_i;
  assign rs1_o       = imem_data_i[19:15];
  assign rs2_o       = imem_data_i[24:20];
  assign rd_o        = imem_data_i[11:7];

  assign opcode  = imem_data_i[6:0];
  assign f_rd    = imem_data_i[11:7];
  assign f_rs1   = imem_data_i[19:15];
  assign f_imm   = imem_data_i[31:20];
  assign is_call = (opcode == 7'b1101111) && (f_rd == 5'd1);
  assign is_ret  = (opcode == 7'b1100111) && (f_rs1 == 5'd1) &&
                   (f_rd == 5'd0) && (f_imm == 12'd0);

  assign look_idx  = pc_q[IDX_W+1:2];
  assign look_tag  = pc_q[DATA_WIDTH-1:IDX_W+2];
  assign btb_hit   = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
  assign btb_taken = btb_hit && btb_ctr[look_idx][1];

  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[DATA_WIDTH-1:IDX_W+2];
  assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

  assign ras_top = ras_mem[ras_ptr - PTR_W'(1)];
  assign ras_hit = is_ret && (ras_count != '0);
  // Speculative state only moves when the PC follows the prediction.
  assign advance = !stall_i && !redirect_i;

  // Prediction is independent of stall/redirect.
  always_comb begin
    pred_taken_o  = 1'b0;
    pred_target_o = pc_plus4;
    if (ras_hit) begin
      pred_taken_o  = 1'b1;
      pred_target_o = ras_top;
    end else if (btb_taken) begin
      pred_taken_o  = 1'b1;
      pred_target_o = btb_target[look_idx];
    end
  end

  always_comb begin
    pc_d = pred_target_o;
    if (redirect_i)   pc_d = redirect_pc_i;
    else if (stall_i) pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  // A push onto a full stack overwrites the oldest entry (circular pointer)
  // while the count saturates at RAS_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr   <= '0;
      ras_count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (advance) begin
      if (is_call) begin
        ras_mem[ras_ptr] <= pc_plus4;
        ras_ptr          <= ras_ptr + PTR_W'(1);
        if (ras_count != CNT_W'(RAS_DEPTH)) ras_count <= ras_count + CNT_W'(1);
      end else if (ras_hit) begin
        ras_ptr   <= ras_ptr - PTR_W'(1);
        ras_count <= ras_count - CNT_W'(1);
      end
    end
  end

  // Registered update: a same-cycle lookup sees the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b01;
      end
    end else if (upd_valid_i) begin
      if (upd_hit) begin
        if (upd_taken_i) begin
          btb_target[upd_idx] <= upd_target_i;
          if (btb_ctr[upd_idx] != 2'b11) btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
        end else begin
          if (btb_ctr[upd_idx] != 2'b00) btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
        end
      end else if (upd_taken_i) begin
        btb_valid[upd_idx]  <= 1'b1;
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= upd_target_i;
        btb_ctr[upd_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_fetch_bp_unit.sv
// Directed bench for fetch_bp_unit: reset, sequential fetch, BTB allocate /
// train / alias, redirect vs stall, RAS call/return incl. overflow and empty
// pop, same-cycle update/lookup, PC wrap and mid-run reset.
module tb_fetch_bp_unit;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADDI = 32'h002081B3; // add x3, x1, x2
  localparam logic [31:0] CALL = 32'h000000EF; // jal x1, 0
  localparam logic [31:0] RET  = 32'h00008067; // jalr x0, 0(x1)

  logic        clk = 1'b0;
  logic        rst, stall, redirect, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target, imem_data;
  logic [31:0] imem_addr, pc, pc_plus4, instr, pred_target;
  logic        pred_taken;
  logic [4:0]  rs1, rs2, rd;

  int n_cmp = 0;
  int n_err = 0;

  fetch_bp_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .upd_valid_i(upd_valid), .upd_pc_i(upd_pc),
    .upd_target_i(upd_target), .upd_taken_i(upd_taken),
    .imem_addr_o(imem_addr), .imem_data_i(imem_data), .pc_o(pc),
    .pc_plus4_o(pc_plus4), .instr_o(instr), .pred_taken_o(pred_taken),
    .pred_target_o(pred_target), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
    upd_valid  = 1'b1;
    upd_pc     = p;
    upd_target = t;
    upd_taken  = tk;
  endtask

  task automatic do_redirect(input logic [31:0] p);
    redirect    = 1'b1;
    redirect_pc = p;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
    imem_data = NOP;
    tick(); tick();
    rst = 1'b0; imem_data = ADDI; #1;

    // reset state and passthrough fields
    chk("rst_pc", pc, 32'hBFC00000);
    chk("rst_addr", imem_addr, 32'hBFC00000);
    chk("rst_pc4", pc_plus4, 32'hBFC00004);
    chk("rst_pred", {31'd0, pred_taken}, 32'd0);
    chk("rst_ptgt", pred_target, 32'hBFC00004);
    chk("instr", instr, ADDI);
    chk("rs1", {27'd0, rs1}, 32'd1);
    chk("rs2", {27'd0, rs2}, 32'd2);
    chk("rd", {27'd0, rd}, 32'd3);

    // free-running sequential fetch
    imem_data = NOP;
    tick(); chk("seq1", pc, 32'hBFC00004);
    tick(); chk("seq2", pc, 32'hBFC00008);
    tick(); chk("seq3", pc, 32'hBFC0000C);
    chk("seq3_pred", {31'd0, pred_taken}, 32'd0);

    // BTB allocate, predict taken
    do_upd(32'hBFC00010, 32'hBFC00100, 1'b1);
    tick(); upd_valid = 1'b0; #1;
    chk("alloc_pc", pc, 32'hBFC00010);
    chk("alloc_pred", {31'd0, pred_taken}, 32'd1);
    chk("alloc_ptgt", pred_target, 32'hBFC00100);
    tick(); chk("alloc_jump", pc, 32'hBFC00100);

    // two not-taken updates: 10 -> 01 -> 00
    do_upd(32'hBFC00010, 32'h0, 1'b0);
    tick(); tick(); upd_valid = 1'b0;

    // redirect overrides stall, then stall holds
    do_redirect(32'hBFC00200); stall = 1'b1;
    tick(); redirect = 1'b0; #1;
    chk("redir_stall", pc, 32'hBFC00200);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("stall_hold", pc, 32'hBFC00200);
    end
    chk("stall_ptgt", pred_target, 32'hBFC00204);
    stall = 1'b0;

    // counter at 00: no prediction
    do_redirect(32'hBFC00010);
    tick(); redirect = 1'b0; #1;
    chk("ctr00_pred", {31'd0, pred_taken}, 32'd0);
    chk("ctr00_ptgt", pred_target, 32'hBFC00014);
    tick(); chk("ctr00_seq", pc, 32'hBFC00014);

    // same-cycle update and lookup while stalled on BFC00010
    do_redirect(32'hBFC00010); stall = 1'b1;
    tick(); redirect = 1'b0;
    do_upd(32'hBFC00010, 32'hBFC00100, 1'b1); #1;
    chk("same_c00", {31'd0, pred_taken}, 32'd0);
    tick(); upd_target = 32'hBFC00300; #1;
    chk("same_c01", {31'd0, pred_taken}, 32'd0);
    tick(); upd_valid = 1'b0; #1;
    chk("same_c10", {31'd0, pred_taken}, 32'd1);
    chk("same_tgt", pred_target, 32'hBFC00300);
    stall = 1'b0;
    tick(); chk("same_jump", pc, 32'hBFC00300);

    // single call / return
    do_redirect(32'hBFC00020);
    tick(); redirect = 1'b0; imem_data = CALL; #1;
    chk("call_pc", pc, 32'hBFC00020);
    chk("call_pred", {31'd0, pred_taken}, 32'd0);
    tick(); imem_data = RET; #1;
    chk("ret_pred", {31'd0, pred_taken}, 32'd1);
    chk("ret_ptgt", pred_target, 32'hBFC00024);
    tick(); #1;
    chk("ret_empty_pred", {31'd0, pred_taken}, 32'd0);
    chk("ret_empty_ptgt", pred_target, 32'hBFC00028);
    tick(); chk("ret_empty_pc", pc, 32'hBFC00028);

    // five nested calls on a 4-deep stack
    imem_data = CALL;
    repeat (5) tick();
    imem_data = RET; #1;
    chk("nest_pc", pc, 32'hBFC0003C);
    for (int i = 0; i < 4; i++) begin
      chk("nest_pred", {31'd0, pred_taken}, 32'd1);
      chk("nest_ptgt", pred_target, 32'hBFC0003C - 32'(4 * i));
      tick();
    end
    chk("nest_end_pc", pc, 32'hBFC00030);
    chk("nest_end_pred", {31'd0, pred_taken}, 32'd0);
    chk("nest_end_ptgt", pred_target, 32'hBFC00034);
    imem_data = NOP;

    // alias: BFC00040 and BFC00080 share index 0
    do_upd(32'hBFC00040, 32'hBFC00500, 1'b1);
    tick(); upd_valid = 1'b0;
    do_redirect(32'hBFC00040);
    tick(); #1;
    chk("aliasA_pred", {31'd0, pred_taken}, 32'd1);
    chk("aliasA_ptgt", pred_target, 32'hBFC00500);
    do_upd(32'hBFC00080, 32'hBFC00600, 1'b1);
    tick(); upd_valid = 1'b0; #1;
    chk("evict_pc", pc, 32'hBFC00040);
    chk("evict_pred", {31'd0, pred_taken}, 32'd0);
    chk("evict_ptgt", pred_target, 32'hBFC00044);
    do_redirect(32'hBFC00080);
    tick(); redirect = 1'b0; #1;
    chk("aliasB_pred", {31'd0, pred_taken}, 32'd1);
    chk("aliasB_ptgt", pred_target, 32'hBFC00600);

    // PC wrap
    do_redirect(32'hFFFFFFFC);
    tick(); redirect = 1'b0; #1;
    chk("wrap_pc4", pc_plus4, 32'h0);
    chk("wrap_ptgt", pred_target, 32'h0);
    tick(); chk("wrap_pc", pc, 32'h0);

    // mid-run reset beats redirect, stall and update
    imem_data = CALL;
    tick();
    rst = 1'b1; stall = 1'b1;
    do_redirect(32'hBFC00080);
    do_upd(32'hBFC00080, 32'hBFC00700, 1'b1);
    tick();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; upd_valid = 1'b0;
    imem_data = RET; #1;
    chk("mid_rst_pc", pc, 32'hBFC00000);
    chk("mid_rst_ras", {31'd0, pred_taken}, 32'd0);
    chk("mid_rst_ptgt", pred_target, 32'hBFC00004);
    imem_data = NOP;
    do_redirect(32'hBFC00080);
    tick(); redirect = 1'b0; #1;
    chk("mid_rst_btb", {31'd0, pred_taken}, 32'd0);
    chk("mid_rst_btgt", pred_target, 32'hBFC00084);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // overall time limit
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
